// File: rtl/reg_pkg.sv
// Shared constants and types for the 8 x 16-bit general register file,
// used by the write side, the read ports and the address decoder.
package reg_pkg;

  localparam int DATA_W = 16;
  localparam int REG_N  = 8;
  localparam int ADDR_W = 3;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: set marks a pending load, clear retires it.
// A set and clear of the same register on one edge leaves it busy.
module reg_scoreboard
  import reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  reg_addr_t        set_addr,
  input  logic             clr_en,
  input  reg_addr_t        clr_addr,
  output logic [REG_N-1:0] busy
);

  logic [REG_N-1:0] busy_q;
  logic [REG_N-1:0] busy_d;

  // Clear is applied before set so a same-address race resolves to busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/write_register.sv
// Write side of the register file: storage, ALU/load write arbitration and a
// one-entry load hold buffer. Optional macro WRITE_REGISTER_R0_ZERO_EN hardwires r0 to zero.
module write_register
  import reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  reg_addr_t        wb_addr,
  input  reg_data_t        wb_data,
  input  logic             ld_valid,
  input  reg_addr_t        ld_addr,
  input  reg_data_t        ld_data,
  output logic             ld_ready,
  input  logic             claim_en,
  input  reg_addr_t        claim_addr,
  output logic [REG_N-1:0] busy,
  output reg_data_t        register0,
  output reg_data_t        register1,
  output reg_data_t        register2,
  output reg_data_t        register3,
  output reg_data_t        register4,
  output reg_data_t        register5,
  output reg_data_t        register6,
  output reg_data_t        register7
);

  reg_data_t regs_q [REG_N];
  logic      holdValid_q, holdValid_d;
  reg_addr_t holdAddr_q, holdAddr_d;
  reg_data_t holdData_q, holdData_d;

  logic      ldAccept;
  logic      wrEn, wrEnEff;
  reg_addr_t wrAddr;
  reg_data_t wrData;
  logic      clrEn;
  reg_addr_t clrAddr;
  logic      claimEff;

  assign ld_ready = !holdValid_q;
  assign ldAccept = ld_valid && ld_ready;

  // One storage write per edge: ALU first, then hold drain, then direct load.
  // An ALU write to the held address makes the held load stale.
  always_comb begin
    wrEn        = 1'b0;
    wrAddr      = '0;
    wrData      = '0;
    clrEn       = 1'b0;
    clrAddr     = '0;
    holdValid_d = holdValid_q;
    holdAddr_d  = holdAddr_q;
    holdData_d  = holdData_q;
    if (wb_en) begin
      wrEn   = 1'b1;
      wrAddr = wb_addr;
      wrData = wb_data;
      if (holdValid_q && (wb_addr == holdAddr_q)) begin
        holdValid_d = 1'b0;
        clrEn       = 1'b1;
        clrAddr     = holdAddr_q;
      end else if (ldAccept) begin
        holdValid_d = 1'b1;
        holdAddr_d  = ld_addr;
        holdData_d  = ld_data;
      end
    end else if (holdValid_q) begin
      wrEn        = 1'b1;
      wrAddr      = holdAddr_q;
      wrData      = holdData_q;
      holdValid_d = 1'b0;
      clrEn       = 1'b1;
      clrAddr     = holdAddr_q;
    end else if (ldAccept) begin
      wrEn    = 1'b1;
      wrAddr  = ld_addr;
      wrData  = ld_data;
      clrEn   = 1'b1;
      clrAddr = ld_addr;
    end
  end

`ifdef WRITE_REGISTER_R0_ZERO_EN
  assign wrEnEff  = wrEn && (wrAddr != '0);
  assign claimEff = claim_en && (claim_addr != '0);
`else
  assign wrEnEff  = wrEn;
  assign claimEff = claim_en;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else if (wrEnEff) begin
      regs_q[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdValid_q <= 1'b0;
      holdAddr_q  <= '0;
      holdData_q  <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      holdAddr_q  <= holdAddr_d;
      holdData_q  <= holdData_d;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (claimEff),
    .set_addr (claim_addr),
    .clr_en   (clrEn),
    .clr_addr (clrAddr),
    .busy     (busy)
  );

`ifdef WRITE_REGISTER_R0_ZERO_EN
  assign register0 = '0;
`else
  assign register0 = regs_q[0];
`endif
  assign register1 = regs_q[1];
  assign register2 = regs_q[2];
  assign register3 = regs_q[3];
  assign register4 = regs_q[4];
  assign register5 = regs_q[5];
  assign register6 = regs_q[6];
  assign register7 = regs_q[7];

endmodule

// File: tb/tb_write_register.sv
// Directed self-checking bench for write_register: ALU writes, direct loads,
// hold collisions, stale holds, scoreboard races and asynchronous reset.
module tb_write_register;
  import reg_pkg::*;

  logic             clk;
  logic             rst;
  logic             wb_en;
  reg_addr_t        wb_addr;
  reg_data_t        wb_data;
  logic             ld_valid;
  reg_addr_t        ld_addr;
  reg_data_t        ld_data;
  logic             ld_ready;
  logic             claim_en;
  reg_addr_t        claim_addr;
  logic [REG_N-1:0] busy;
  reg_data_t        regOut [REG_N];

  int checkCount;
  int errorCount;

  write_register dut (
    .clk        (clk),
    .rst        (rst),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy       (busy),
    .register0  (regOut[0]),
    .register1  (regOut[1]),
    .register2  (regOut[2]),
    .register3  (regOut[3]),
    .register4  (regOut[4]),
    .register5  (regOut[5]),
    .register6  (regOut[6]),
    .register7  (regOut[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, sample 1ns after the edge, then return to idle.
  task automatic applyStimulus(input logic wbEn, input int wbAddr, input logic [15:0] wbData,
                               input logic ldValid, input int ldAddr, input logic [15:0] ldData,
                               input logic claimEn, input int claimAddr);
    wb_en      = wbEn;
    wb_addr    = reg_addr_t'(wbAddr);
    wb_data    = wbData;
    ld_valid   = ldValid;
    ld_addr    = reg_addr_t'(ldAddr);
    ld_data    = ldData;
    claim_en   = claimEn;
    claim_addr = reg_addr_t'(claimAddr);
    @(posedge clk);
    #1;
    wb_en    = 1'b0;
    ld_valid = 1'b0;
    claim_en = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst        = 1'b1;
    wb_en      = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    ld_valid   = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_reg3", regOut[3], 16'h0000);
    checkOutput("reset_busy", {8'h00, busy}, 16'h0000);
    checkOutput("reset_ready", {15'h0, ld_ready}, 16'h0001);
    rst = 1'b0;

    $display("[TB] ALU write");
    applyStimulus(1'b1, 3, 16'hBEEF, 1'b0, 0, 16'h0, 1'b0, 0);
    checkOutput("alu_reg3", regOut[3], 16'hBEEF);
    checkOutput("alu_reg2", regOut[2], 16'h0000);
    checkOutput("alu_reg4", regOut[4], 16'h0000);

    $display("[TB] Direct load");
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, 5);
    checkOutput("claim5_busy", {8'h00, busy}, 16'h0020);
    applyStimulus(1'b0, 0, 16'h0, 1'b1, 5, 16'h1234, 1'b0, 0);
    checkOutput("dload_reg5", regOut[5], 16'h1234);
    checkOutput("dload_busy", {8'h00, busy}, 16'h0000);
    checkOutput("dload_ready", {15'h0, ld_ready}, 16'h0001);

    $display("[TB] Collision");
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, 2);
    applyStimulus(1'b1, 6, 16'h5555, 1'b1, 2, 16'h00AA, 1'b0, 0);
    checkOutput("coll_reg6", regOut[6], 16'h5555);
    checkOutput("coll_ready", {15'h0, ld_ready}, 16'h0000);
    checkOutput("coll_reg2_pending", regOut[2], 16'h0000);
    checkOutput("coll_busy_pending", {8'h00, busy}, 16'h0004);
    idleCycle();
    checkOutput("drain_reg2", regOut[2], 16'h00AA);
    checkOutput("drain_ready", {15'h0, ld_ready}, 16'h0001);
    checkOutput("drain_busy", {8'h00, busy}, 16'h0000);

    $display("[TB] Stale hold");
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, 4);
    applyStimulus(1'b1, 7, 16'h7777, 1'b1, 4, 16'h1111, 1'b0, 0);
    checkOutput("stale_reg7", regOut[7], 16'h7777);
    checkOutput("stale_held_ready", {15'h0, ld_ready}, 16'h0000);
    applyStimulus(1'b1, 4, 16'h2222, 1'b0, 0, 16'h0, 1'b0, 0);
    checkOutput("stale_reg4", regOut[4], 16'h2222);
    checkOutput("stale_busy", {8'h00, busy}, 16'h0000);
    checkOutput("stale_ready", {15'h0, ld_ready}, 16'h0001);
    idleCycle();
    checkOutput("stale_reg4_final", regOut[4], 16'h2222);

    $display("[TB] Scoreboard race");
    applyStimulus(1'b0, 0, 16'h0, 1'b1, 1, 16'h0101, 1'b1, 1);
    checkOutput("race_reg1", regOut[1], 16'h0101);
    checkOutput("race_busy", {8'h00, busy}, 16'h0002);
    applyStimulus(1'b0, 0, 16'h0, 1'b1, 1, 16'h0202, 1'b0, 0);
    checkOutput("race_clear_busy", {8'h00, busy}, 16'h0000);

    $display("[TB] Reset mid-operation");
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, 2);
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, 5);
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, 5);
    checkOutput("reclaim_busy", {8'h00, busy}, 16'h0024);
    applyStimulus(1'b1, 7, 16'h0707, 1'b1, 2, 16'h0F0F, 1'b0, 0);
    checkOutput("prerst_ready", {15'h0, ld_ready}, 16'h0000);
    checkOutput("prerst_busy", {8'h00, busy}, 16'h0024);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_reg3", regOut[3], 16'h0000);
    checkOutput("arst_reg7", regOut[7], 16'h0000);
    checkOutput("arst_busy", {8'h00, busy}, 16'h0000);
    checkOutput("arst_ready", {15'h0, ld_ready}, 16'h0001);
    rst = 1'b0;
    idleCycle();
    checkOutput("arst_hold_lost", regOut[2], 16'h0000);

    $display("[TB] Register 0");
    applyStimulus(1'b1, 0, 16'hFFFF, 1'b0, 0, 16'h0, 1'b0, 0);
`ifdef WRITE_REGISTER_R0_ZERO_EN
    checkOutput("r0_alu", regOut[0], 16'h0000);
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, 0);
    checkOutput("r0_claim", {8'h00, busy}, 16'h0000);
    applyStimulus(1'b0, 0, 16'h0, 1'b1, 0, 16'h1357, 1'b0, 0);
    checkOutput("r0_load", regOut[0], 16'h0000);
    checkOutput("r0_ready", {15'h0, ld_ready}, 16'h0001);
`else
    checkOutput("r0_alu", regOut[0], 16'hFFFF);
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, 0);
    checkOutput("r0_claim", {8'h00, busy}, 16'h0001);
    applyStimulus(1'b0, 0, 16'h0, 1'b1, 0, 16'h1357, 1'b0, 0);
    checkOutput("r0_load", regOut[0], 16'h1357);
    checkOutput("r0_busy_clear", {8'h00, busy}, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
